hazard_ctrl: RTL and testbench

Pipeline hazard controller for the Mini-RISC-V 5-stage core. It sits beside the operand-forwarding datapath and covers the hazards forwarding cannot resolve:
- load-use: inserts one bubble.
- taken branch/jump: flushes the IF/ID and ID/EX registers.
- multi-cycle mul/div in EX: freezes the front of the pipe until the unit completes, with a timeout.
It also keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {RUN, MD_WAIT} hz_state_t;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  localparam logic [4:0] NOP_RD = 5'd0;

  function automatic logic srcHit(input logic useSrc,
                                  input logic [4:0] rs,
                                  input logic [4:0] rd);
    return useSrc & (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard sources in, stall/flush controls out.
interface hazard_ctrl_if #(parameter int CNT_W = 32);

  logic             ID_EX_memread;
  logic [4:0]       ID_EX_rd;
  logic             ID_EX_md;
  logic [4:0]       IF_ID_rs1;
  logic [4:0]       IF_ID_rs2;
  logic             IF_ID_use_rs1;
  logic             IF_ID_use_rs2;
  logic             EX_branch_taken;
  logic             md_done;
  logic             md_go;
  logic             PC_stall;
  logic             IF_ID_stall;
  logic             ID_EX_stall;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_bubble;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output ID_EX_memread, ID_EX_rd, ID_EX_md, IF_ID_rs1, IF_ID_rs2,
           IF_ID_use_rs1, IF_ID_use_rs2, EX_branch_taken, md_done,
    input  md_go, PC_stall, IF_ID_stall, ID_EX_stall, IF_ID_flush,
           ID_EX_flush, EX_MEM_bubble, md_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  ID_EX_memread, ID_EX_rd, ID_EX_md, IF_ID_rs1, IF_ID_rs2,
           IF_ID_use_rs1, IF_ID_use_rs2, EX_branch_taken, md_done,
    output md_go, PC_stall, IF_ID_stall, ID_EX_stall, IF_ID_flush,
           ID_EX_flush, EX_MEM_bubble, md_timeout, stall_cycles, flush_events
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubble, branch flush,
// multi-cycle mul/div freeze with timeout, and stall/flush perf counters.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic         clk,
  input  logic         Rst,
  hazard_ctrl_if.slave hz
);

  localparam int WCW = $clog2(MD_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MD_TIMEOUT - 1);

  hz_state_t      r_state;
  hz_state_t      w_nextState;
  logic [WCW-1:0] r_waitCnt;
  logic [WCW-1:0] w_nextWaitCnt;

  logic w_loadUse;
  logic w_mdGo;
  logic w_frontStall;
  logic w_exStall;
  logic w_ifFlush;
  logic w_idFlush;
  logic w_bubble;
  logic w_timeout;
  logic [CNT_W-1:0] w_stallCnt;
  logic [CNT_W-1:0] w_flushCnt;

  assign w_loadUse = hz.ID_EX_memread & (hz.ID_EX_rd != NOP_RD) &
                     (srcHit(hz.IF_ID_use_rs1, hz.IF_ID_rs1, hz.ID_EX_rd) |
                      srcHit(hz.IF_ID_use_rs2, hz.IF_ID_rs2, hz.ID_EX_rd));

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= RUN;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_mdGo        = 1'b0;
    w_frontStall  = 1'b0;
    w_exStall     = 1'b0;
    w_ifFlush     = 1'b0;
    w_idFlush     = 1'b0;
    w_bubble      = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      RUN: begin
        // A taken branch discards the ID instruction, so its load-use hazard is moot
        if (hz.EX_branch_taken) begin
          w_ifFlush = 1'b1;
          w_idFlush = 1'b1;
        end else if (hz.ID_EX_md && !hz.md_done) begin
          w_mdGo        = 1'b1;
          w_frontStall  = 1'b1;
          w_exStall     = 1'b1;
          w_bubble      = 1'b1;
          w_nextState   = MD_WAIT;
          w_nextWaitCnt = '0;
        end else if (hz.ID_EX_md) begin
          w_mdGo = 1'b1;
        end else if (w_loadUse) begin
          w_frontStall = 1'b1;
          w_idFlush    = 1'b1;
        end
      end
      MD_WAIT: begin
        if (hz.md_done) begin
          w_nextState   = RUN;
          w_nextWaitCnt = '0;
        end else if (r_waitCnt == WAIT_LAST) begin
          w_timeout     = 1'b1;
          w_nextState   = RUN;
          w_nextWaitCnt = '0;
        end else begin
          w_frontStall  = 1'b1;
          w_exStall     = 1'b1;
          w_bubble      = 1'b1;
          w_nextWaitCnt = r_waitCnt + WCW'(1);
        end
      end
      default: begin
        w_nextState   = RUN;
        w_nextWaitCnt = '0;
      end
    endcase
  end

  // Reset silences every control line immediately, without waiting for a clock
  assign hz.md_go         = w_mdGo       & ~Rst;
  assign hz.PC_stall      = w_frontStall & ~Rst;
  assign hz.IF_ID_stall   = w_frontStall & ~Rst;
  assign hz.ID_EX_stall   = w_exStall    & ~Rst;
  assign hz.IF_ID_flush   = w_ifFlush    & ~Rst;
  assign hz.ID_EX_flush   = w_idFlush    & ~Rst;
  assign hz.EX_MEM_bubble = w_bubble     & ~Rst;
  assign hz.md_timeout    = w_timeout    & ~Rst;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .Rst   (Rst),
    .inc   (hz.PC_stall),
    .count (w_stallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flushCnt (
    .clk   (clk),
    .Rst   (Rst),
    .inc   (hz.IF_ID_flush),
    .count (w_flushCnt)
  );

  assign hz.stall_cycles = w_stallCnt;
  assign hz.flush_events = w_flushCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected controls, a negedge monitor checks them.
module tb_hazard_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = 15;

  // Expected control word layout: {go, pcStall, ifStall, idStall, ifFlush, idFlush, bubble, timeout}
  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_LU   = 8'b0110_0100;
  localparam logic [7:0] E_BR   = 8'b0000_1100;
  localparam logic [7:0] E_MD   = 8'b1111_0010;
  localparam logic [7:0] E_WAIT = 8'b0111_0010;
  localparam logic [7:0] E_GO   = 8'b1000_0000;
  localparam logic [7:0] E_TMO  = 8'b0000_0001;

  typedef struct {
    int             vecId;
    logic [7:0]     ctrl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic Rst = 1'b1;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   vecCount = 0;
  int   modelStall = 0;
  int   modelFlush = 0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hzIf ();

  hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .Rst (Rst),
    .hz  (hzIf)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs just after the rising edge and queues what the DUT must show that cycle
  task automatic applyStimulus(input logic rst, input logic memread, input logic [4:0] rd,
                               input logic md, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2, input logic br,
                               input logic done, input logic [7:0] expCtrl);
    exp_t e;
    @(posedge clk);
    #1;
    Rst                  = rst;
    hzIf.ID_EX_memread   = memread;
    hzIf.ID_EX_rd        = rd;
    hzIf.ID_EX_md        = md;
    hzIf.IF_ID_rs1       = rs1;
    hzIf.IF_ID_rs2       = rs2;
    hzIf.IF_ID_use_rs1   = use1;
    hzIf.IF_ID_use_rs2   = use2;
    hzIf.EX_branch_taken = br;
    hzIf.md_done         = done;
    e.vecId = vecCount;
    e.ctrl  = expCtrl;
    e.stall = rst ? '0 : CNT_W'(modelStall);
    e.flush = rst ? '0 : CNT_W'(modelFlush);
    expQ.push_back(e);
    vecCount++;
    if (rst) begin
      modelStall = 0;
      modelFlush = 0;
    end else begin
      if (expCtrl[6] && modelStall < CNT_MAX) modelStall++;
      if (expCtrl[3] && modelFlush < CNT_MAX) modelFlush++;
    end
  endtask

  task automatic idle(input logic [7:0] expCtrl);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, expCtrl);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
  endtask

  task automatic mdCycle(input logic done, input logic [7:0] expCtrl);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, done, expCtrl);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {hzIf.md_go, hzIf.PC_stall, hzIf.IF_ID_stall, hzIf.ID_EX_stall,
           hzIf.IF_ID_flush, hzIf.ID_EX_flush, hzIf.EX_MEM_bubble, hzIf.md_timeout};
    checks++;
    if (act !== e.ctrl) begin
      failures++;
      $display("[TB] FAIL ctrl vec=%0d actual=%b required=%b", e.vecId, act, e.ctrl);
    end
    checks++;
    if (hzIf.stall_cycles !== e.stall) begin
      failures++;
      $display("[TB] FAIL stall_cycles vec=%0d actual=%0d required=%0d", e.vecId, hzIf.stall_cycles, e.stall);
    end
    checks++;
    if (hzIf.flush_events !== e.flush) begin
      failures++;
      $display("[TB] FAIL flush_events vec=%0d actual=%0d required=%0d", e.vecId, hzIf.flush_events, e.flush);
    end
  endtask

  // Monitor: every falling edge, the oldest pending expectation is compared against the DUT
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    hzIf.ID_EX_memread   = 1'b0;
    hzIf.ID_EX_rd        = 5'd0;
    hzIf.ID_EX_md        = 1'b0;
    hzIf.IF_ID_rs1       = 5'd0;
    hzIf.IF_ID_rs2       = 5'd0;
    hzIf.IF_ID_use_rs1   = 1'b0;
    hzIf.IF_ID_use_rs2   = 1'b0;
    hzIf.EX_branch_taken = 1'b0;
    hzIf.md_done         = 1'b0;

    doReset();
    idle(E_NONE);

    // Load-use on rs2, then the bubble has cleared memread
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, E_LU);
    applyStimulus(1'b0, 1'b0, 5'd5, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, E_NONE);
    // x0 destination and unused source never stall; a used rs1 does
    applyStimulus(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE);
    applyStimulus(1'b0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    applyStimulus(1'b0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    applyStimulus(1'b0, 1'b1, 5'd7, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, E_NONE);
    // Branch outranks a simultaneous load-use
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, E_BR);
    idle(E_NONE);
    // Zero-latency mul/div, then a stray md_done with no mul/div in EX
    mdCycle(1'b1, E_GO);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_NONE);
    idle(E_NONE);

    // Four-cycle mul/div; branch and load-use inside MD_WAIT are ignored
    doReset();
    idle(E_NONE);
    mdCycle(1'b0, E_MD);
    mdCycle(1'b0, E_WAIT);
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_WAIT);
    mdCycle(1'b0, E_WAIT);
    mdCycle(1'b1, E_NONE);
    idle(E_NONE);
    idle(E_NONE);

    // Timeout after MD_TIMEOUT cycles in MD_WAIT
    doReset();
    idle(E_NONE);
    mdCycle(1'b0, E_MD);
    for (int i = 0; i < MD_TIMEOUT - 1; i++) mdCycle(1'b0, E_WAIT);
    mdCycle(1'b0, E_TMO);
    idle(E_NONE);
    idle(E_NONE);

    // Reset during MD_WAIT drops everything at once and never pulses timeout
    doReset();
    idle(E_NONE);
    mdCycle(1'b0, E_MD);
    for (int i = 0; i < 3; i++) mdCycle(1'b0, E_WAIT);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
    for (int i = 0; i < MD_TIMEOUT + 2; i++) idle(E_NONE);

    // Stall counter saturation
    doReset();
    idle(E_NONE);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    idle(E_NONE);
    idle(E_NONE);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
